// File: rtl/plic_gateway_pkg.sv
// Shared PLIC definitions: sizes, register-block request struct and the
// per-source gateway state encoding.
package plic_gateway_pkg;

  localparam int PLIC_SOURCE_COUNT = 2;
  localparam int PLIC_TARGET_COUNT = 2;
  // Wide enough for IDs 0..PLIC_SOURCE_COUNT; ID 0 means "no source".
  localparam int PLIC_SOURCE_WIDTH = 2;

  typedef struct packed {
    logic [PLIC_TARGET_COUNT-1:0]                        claim_req;
    logic [PLIC_TARGET_COUNT-1:0]                        complete_req;
    logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_WIDTH-1:0] complete_idx;
  } type_regs2gateway_s;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

  // Source index (0-based) to interrupt ID (1-based).
  function automatic logic [PLIC_SOURCE_WIDTH-1:0] src_id(input int idx);
    return PLIC_SOURCE_WIDTH'(idx + 1);
  endfunction

endpackage

// File: rtl/plic_gateway_cell.sv
// One interrupt source: 2-flop synchroniser, saturating edge counter (edge
// mode only) and the IDLE/PENDING/CLAIMED gateway FSM. The FSM state is
// exported so the parent can derive pending and checkers can observe it.
module plic_gateway_cell
  import plic_gateway_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b0,
  parameter int CNT_W     = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      irq_src,
  input  logic      claim,
  input  logic      complete,
  output gw_state_e state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1, sync2, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gw_state_e        state_q, state_d;
  logic             edge_det, dec, raise;

  // Synchroniser plus one extra stage of history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1   <= irq_src;
      sync2   <= sync1;
      sync2_q <= sync2;
    end
  end

  assign edge_det = EDGE_MODE && sync2 && !sync2_q;
  // A claim only consumes an edge when it actually takes the source.
  assign dec      = EDGE_MODE && claim && (state_q == GW_PENDING);
  assign raise    = EDGE_MODE ? ((cnt_q != '0) || edge_det) : sync2;

  // Saturating edge counter; a saturated counter loses the new edge when a
  // claim decrements in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_det && dec) begin
      if (cnt_q == CNT_MAX) cnt_d = cnt_q - CNT_ONE;
    end else if (edge_det) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Gateway FSM next state: claims and completions are ignored outside the
  // state that accepts them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GW_IDLE:    if (raise)    state_d = GW_PENDING;
      GW_PENDING: if (claim)    state_d = GW_CLAIMED;
      GW_CLAIMED: if (complete) state_d = GW_IDLE;
      default:                  state_d = GW_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GW_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/plic_gateway.sv
// PLIC gateway: detects new claims per target, decodes claim/complete IDs
// into one-hot per-source strobes and runs one gateway cell per source.
//
// Request semantics: claim_req[t] is a level from the register block; only
// its first high cycle is a claim event, taking the ID on claim_idx_i[t] in
// that same cycle. complete_req[t] is a single-cycle strobe qualified by
// complete_idx[t]. ID 0 or IDs above the source count decode to nothing.
module plic_gateway
  import plic_gateway_pkg::*;
#(
  parameter logic [PLIC_SOURCE_COUNT-1:0] PLIC_EDGE_MASK  = '0,
  parameter int                           PLIC_EDGE_CNT_W = 2
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [PLIC_SOURCE_COUNT-1:0]                      irq_src_i,
  input  type_regs2gateway_s                                regs2gateway_i,
  input  logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_WIDTH-1:0] claim_idx_i,
  output logic [PLIC_SOURCE_COUNT-1:0]                      irq_pending_o
);

  logic [PLIC_TARGET_COUNT-1:0] claim_q;
  logic [PLIC_TARGET_COUNT-1:0] claim_ev;
  logic [PLIC_SOURCE_COUNT-1:0] claim_hit;
  logic [PLIC_SOURCE_COUNT-1:0] complete_hit;
  gw_state_e                    cell_state [PLIC_SOURCE_COUNT];

  // Registered copy of claim_req so a held request claims only once.
  always_ff @(posedge clk) begin
    if (rst) claim_q <= '0;
    else     claim_q <= regs2gateway_i.claim_req;
  end

  assign claim_ev = regs2gateway_i.claim_req & ~claim_q;

  // Decode per-target IDs into per-source strobes; several targets naming
  // the same ID merge into one strobe.
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int s = 0; s < PLIC_SOURCE_COUNT; s++) begin
      for (int t = 0; t < PLIC_TARGET_COUNT; t++) begin
        if (claim_ev[t] && (claim_idx_i[t] == src_id(s)))
          claim_hit[s] = 1'b1;
        if (regs2gateway_i.complete_req[t] &&
            (regs2gateway_i.complete_idx[t] == src_id(s)))
          complete_hit[s] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < PLIC_SOURCE_COUNT; g++) begin : g_cell
    plic_gateway_cell #(
      .EDGE_MODE (PLIC_EDGE_MASK[g]),
      .CNT_W     (PLIC_EDGE_CNT_W)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .irq_src  (irq_src_i[g]),
      .claim    (claim_hit[g]),
      .complete (complete_hit[g]),
      .state_o  (cell_state[g])
    );
    // Pending is a pure decode of the registered FSM state.
    assign irq_pending_o[g] = (cell_state[g] == GW_PENDING);
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: one all-level instance and one with source 1 in
// edge mode share the same stimulus; a behavioural model predicts the
// pending vector of each after every clock edge.
module tb_plic_gateway;
  import plic_gateway_pkg::*;

  localparam int S = PLIC_SOURCE_COUNT;
  localparam int T = PLIC_TARGET_COUNT;
  localparam int W = PLIC_SOURCE_WIDTH;
  localparam logic [S-1:0] MASK_LVL  = 2'b00;
  localparam logic [S-1:0] MASK_EDG  = 2'b01;
  localparam int           OWED_MAX  = 3;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic rst;
  logic [S-1:0]        irq_src;
  type_regs2gateway_s  r2g;
  logic [T-1:0][W-1:0] claim_idx;
  logic [S-1:0]        pend_lvl, pend_edg;

  always #5 clk = ~clk;

  plic_gateway #(.PLIC_EDGE_MASK(MASK_LVL), .PLIC_EDGE_CNT_W(2)) dut_lvl (
    .clk(clk), .rst(rst), .irq_src_i(irq_src), .regs2gateway_i(r2g),
    .claim_idx_i(claim_idx), .irq_pending_o(pend_lvl)
  );

  plic_gateway #(.PLIC_EDGE_MASK(MASK_EDG), .PLIC_EDGE_CNT_W(2)) dut_edg (
    .clk(clk), .rst(rst), .irq_src_i(irq_src), .regs2gateway_i(r2g),
    .claim_idx_i(claim_idx), .irq_pending_o(pend_edg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2*S-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per source: what the gateway owes the system. status 0 = quiet,
  // 1 = waiting for a target, 2 = being serviced. owed = edges not yet handed out.
  logic [S-1:0] line_q[$];       // raw line samples still inside the synchroniser
  logic [S-1:0] vis_prev;
  logic [T-1:0] m_claim_prev;
  int           m_status [2][S];
  int           m_owed   [2][S];

  function automatic bit is_edge(input int d, input int s);
    logic [S-1:0] m;
    m = (d == 0) ? MASK_LVL : MASK_EDG;
    return m[s];
  endfunction

  task automatic model_tick();
    logic [S-1:0] vis, rise, hit_claim, hit_done;
    logic [2*S-1:0] e;
    int old_st, old_owed;
    bit wants;
    if (rst) begin
      line_q.delete();
      line_q.push_back('0);
      line_q.push_back('0);
      vis_prev     = '0;
      m_claim_prev = '0;
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < S; s++) begin
          m_status[d][s] = 0;
          m_owed[d][s]   = 0;
        end
    end else begin
      vis  = line_q.pop_front();
      rise = vis & ~vis_prev;
      hit_claim = '0;
      hit_done  = '0;
      for (int s = 0; s < S; s++)
        for (int t = 0; t < T; t++) begin
          if (r2g.claim_req[t] && !m_claim_prev[t] && (int'(claim_idx[t]) == s + 1))
            hit_claim[s] = 1'b1;
          if (r2g.complete_req[t] && (int'(r2g.complete_idx[t]) == s + 1))
            hit_done[s] = 1'b1;
        end
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < S; s++) begin
          old_st   = m_status[d][s];
          old_owed = m_owed[d][s];
          if (is_edge(d, s)) begin
            m_owed[d][s] = ((old_owed + int'(rise[s])) > OWED_MAX) ? OWED_MAX
                           : (old_owed + int'(rise[s]));
            if (old_st == 1 && hit_claim[s]) m_owed[d][s] = m_owed[d][s] - 1;
            wants = (old_owed > 0) || rise[s];
          end else begin
            wants = vis[s];
          end
          if (old_st == 0 && wants)            m_status[d][s] = 1;
          else if (old_st == 1 && hit_claim[s]) m_status[d][s] = 2;
          else if (old_st == 2 && hit_done[s])  m_status[d][s] = 0;
        end
      vis_prev     = vis;
      m_claim_prev = r2g.claim_req;
      line_q.push_back(irq_src);
    end
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < S; s++)
        e[d*S + s] = (m_status[d][s] == 1);
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [2*S-1:0] e;
    @(posedge clk);
    model_tick();
    @(negedge clk);
    e = exp_q.pop_front();
    check("pend_lvl", 32'(pend_lvl), 32'(e[S-1:0]));
    check("pend_edg", 32'(pend_edg), 32'(e[2*S-1:S]));
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_claim(input int t, input int id);
    r2g.claim_req[t] = 1'b1;
    claim_idx[t]     = W'(id);
    step();
    r2g.claim_req[t] = 1'b0;
  endtask

  task automatic do_complete(input int t, input int id);
    r2g.complete_req[t] = 1'b1;
    r2g.complete_idx[t] = W'(id);
    step();
    r2g.complete_req[t] = 1'b0;
  endtask

  task automatic pulse_src(input int s);
    irq_src[s] = 1'b1;
    steps(2);
    irq_src[s] = 1'b0;
    steps(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    irq_src   = '0;
    r2g       = '0;
    claim_idx = '0;
    steps(2);
    check("rst_lvl", 32'(pend_lvl), 32'h0);
    rst = 1'b0;
    steps(1);

    // Level hold: source 1 raised, pending after third edge, survives drop.
    irq_src[0] = 1'b1;
    steps(3);
    check("lat_lvl", 32'(pend_lvl), 32'h1);
    check("lat_edg", 32'(pend_edg), 32'h1);
    steps(1);
    irq_src[0] = 1'b0;
    steps(3);
    check("hold_lvl", 32'(pend_lvl), 32'h1);
    do_claim(0, 1);
    do_complete(0, 1);
    steps(3);

    // Held claim of source 2, then completion with line low.
    irq_src[1] = 1'b1;
    steps(4);
    r2g.claim_req[0] = 1'b1;
    claim_idx[0]     = W'(2);
    steps(1);
    check("claim_lvl", 32'(pend_lvl), 32'h0);
    steps(2);
    r2g.claim_req[0] = 1'b0;
    irq_src[1]       = 1'b0;
    steps(2);
    do_complete(0, 2);
    steps(3);
    check("no_repend", 32'(pend_lvl), 32'h0);

    // Edge source 1: counter saturation while claimed, then drain.
    pulse_src(0);
    do_claim(0, 1);
    repeat (5) pulse_src(0);
    for (int r = 0; r < 4; r++) begin
      do_complete(0, 1);
      steps(2);
      if (r < 3) begin
        check("edg_repend", 32'(pend_edg[0]), 32'h1);
        do_claim(0, 1);
      end else begin
        check("edg_drained", 32'(pend_edg[0]), 32'h0);
      end
    end
    steps(2);

    // Dual-target claim of ID 1 coinciding with a new edge at owed=1.
    pulse_src(0);
    irq_src[0] = 1'b1;
    steps(2);
    r2g.claim_req = '1;
    claim_idx[0]  = W'(1);
    claim_idx[1]  = W'(1);
    step();
    r2g.claim_req = '0;
    irq_src[0]    = 1'b0;
    check("dual_claim", 32'(pend_edg[0]), 32'h0);
    steps(3);
    do_complete(0, 1);
    steps(2);
    check("cnt_kept", 32'(pend_edg[0]), 32'h1);
    do_claim(1, 1);
    do_complete(1, 1);
    steps(2);
    check("cnt_empty", 32'(pend_edg[0]), 32'h0);
    do_complete(0, 1);
    steps(3);

    // Ignored requests, then reset while claimed.
    irq_src[1] = 1'b1;
    steps(4);
    do_complete(0, 2);
    check("stray_done", 32'(pend_lvl[1]), 32'h1);
    do_claim(0, 0);
    check("id0_claim", 32'(pend_lvl[1]), 32'h1);
    do_claim(1, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_clear", 32'(pend_lvl), 32'h0);
    steps(2);
    check("rst_wait", 32'(pend_lvl[1]), 32'h0);
    step();
    check("rst_repend", 32'(pend_lvl[1]), 32'h1);
    irq_src = '0;
    do_complete(0, 2);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) irq_src = S'($urandom_range(0, 3));
      for (int t = 0; t < T; t++) begin
        if ($urandom_range(0, 2) == 0) r2g.claim_req[t] = ~r2g.claim_req[t];
        claim_idx[t]        = W'($urandom_range(0, 3));
        r2g.complete_req[t] = ($urandom_range(0, 4) == 0);
        r2g.complete_idx[t] = W'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0;
    r2g = '0;
    steps(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/plic_gateway.md
PLIC_GATEWAY -- requirements
Module: plic_gateway

Interface
REQ-001 Parameter PLIC_EDGE_MASK, default '0 (PLIC_SOURCE_COUNT bits), bit i=1 makes source ID i+1 edge-triggered, 0 makes it level-triggered.
REQ-002 Parameter PLIC_EDGE_CNT_W, default 2, is the width of the per-source saturating edge counter.
REQ-003 Port clk, input, 1, the block's only clock.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port irq_src_i, input, PLIC_SOURCE_COUNT, raw external interrupt lines; bit i is source ID i+1 and is asynchronous to clk.
REQ-006 Port regs2gateway_i, input, type_regs2gateway_s: claim_req, complete_req and complete_idx per target from the register block.
REQ-007 Port claim_idx_i, input, PLIC_TARGET_COUNT x PLIC_SOURCE_WIDTH, the ID currently offered to each target by the target stage; 0 means none.
REQ-008 Port irq_pending_o, output, PLIC_SOURCE_COUNT, registered pending bit per source, consumed by the register block and the target stage.

Function
REQ-009 Each source SHALL pass through a 2-flop synchroniser (sync1, sync2) before any other use.
REQ-010 Each source SHALL hold one FSM with states IDLE, PENDING and CLAIMED; irq_pending_o[i] SHALL be 1 exactly when the state is PENDING.
REQ-011 Level mode: IDLE goes to PENDING when sync2=1; PENDING holds even if the line drops, until claimed.
REQ-012 Edge mode: a rising edge (sync2=1 and previous sync2=0) SHALL increment the edge counter, saturating at 2^PLIC_EDGE_CNT_W-1.
REQ-013 Edge mode: IDLE goes to PENDING when the counter is nonzero or an edge is detected in the same cycle.
REQ-014 A claim event for target t SHALL be the first cycle of claim_req[t] high (rising edge against a registered copy); a held claim_req SHALL NOT claim again.
REQ-015 PENDING goes to CLAIMED on a claim event from any target with claim_idx_i[t]=i+1; in edge mode the counter decrements in the same cycle.
REQ-016 A simultaneous claim of the same ID by two targets SHALL cause a single transition and a single decrement.
REQ-017 A simultaneous rising edge and decrement SHALL leave the counter unchanged, unless it is saturated, in which case it decrements.
REQ-018 CLAIMED goes to IDLE when complete_req[t]=1 with complete_idx[t]=i+1 for any t.
REQ-019 A completion for a source not in CLAIMED, and any claim or complete with ID 0 or ID > PLIC_SOURCE_COUNT, SHALL be ignored.
REQ-020 While a source is CLAIMED, further edges SHALL still count, but the source SHALL NOT re-raise pending until completion.
REQ-021 After a completion, a still-high level or a nonzero counter SHALL re-assert irq_pending_o one cycle after the return to IDLE.
REQ-022 Latency: with irq_src_i high before clock edge 1 and the source IDLE, irq_pending_o SHALL be 1 after edge 3, in both modes.
REQ-023 The block SHALL contain no combinational path from any input to irq_pending_o.

Reset
REQ-024 While rst=1 at a clock edge, all of the following SHALL clear: FSMs to IDLE, counters to 0, sync flops to 0, claim_req history to 0, irq_pending_o to 0.
REQ-025 Reset mid-operation SHALL abandon any CLAIMED state; a still-high level source SHALL re-pend 3 cycles after rst deasserts.

Structure
REQ-026 The shared PLIC defs package SHALL hold PLIC_SOURCE_COUNT, PLIC_TARGET_COUNT, PLIC_SOURCE_WIDTH, type_regs2gateway_s and the gateway FSM state enum.
REQ-027 The per-source synchroniser, counter and FSM SHALL be a sub-module plic_gateway_cell, instantiated PLIC_SOURCE_COUNT times by generate.
REQ-028 Claim-edge detection and ID decode SHALL live in plic_gateway and feed each cell one-hot claim/complete strobes.

Verification
REQ-029 Level source 1 held high, no claim -> irq_pending_o=2'b01 from cycle 3 onward; line drop at cycle 5 -> still 2'b01.
REQ-030 Pending source 2, claim_req[0] held for 3 cycles with claim_idx_i[0]=2 -> pending 0 the next cycle, one claim only; complete_idx[0]=2 with line low -> stays 0.
REQ-031 Edge source 1 (PLIC_EDGE_MASK=2'b01), 5 pulses while CLAIMED -> counter saturates at 3; 3 claim/complete rounds each re-pend, and a 4th does not.
REQ-032 Both targets claim ID 1 in the same cycle, with an edge arriving the same cycle at counter=1 -> one CLAIMED transition, counter stays 1.
REQ-033 Complete of ID 2 while source 2 is PENDING, and claim with ID 0 -> no state change; rst pulsed while CLAIMED with level high -> pending 0, then 1 three cycles after rst falls.
